// File: rtl/cclimb_dl_sequencer.sv
// ROM download sequencer for the crazy_climber core: re-times the hps_io byte stream onto the
// core's dn_* port, validates the load and owns the core reset.
module cclimb_dl_sequencer #(
  parameter logic [15:0] PROG_END = 16'h6000,
  parameter logic [15:0] GFX_END  = 16'h9000,
  parameter logic [15:0] TOTAL    = 16'hA000,
  parameter int unsigned SETTLE   = 1024
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        slot_en,
  input  logic        user_reset,
  output logic [15:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        dn_wr,
  output logic [2:0]  region_sel,
  output logic        core_reset,
  output logic        dl_done,
  output logic        dl_error,
  output logic [15:0] byte_count
);

  localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(SETTLE - 1);

  typedef enum logic [2:0] {StBoot, StLoad, StCheck, StSettle, StRun} state_e;

  state_e          state_q;
  logic            core_reset_q;
  logic            dl_done_q;
  logic            dl_error_q;
  logic [15:0]     byte_count_q;
  logic [CntW-1:0] settle_cnt_q;
  logic            pend_q;
  logic [15:0]     pend_addr_q;
  logic [7:0]      pend_data_q;
  logic [2:0]      pend_region_q;

  logic       drain;
  logic       addr_ok;
  logic       wr_load;
  logic       accept;
  logic [2:0] region_dec;

  always_comb begin
    drain   = pend_q & slot_en;
    addr_ok = (ioctl_addr[24:16] == 9'd0) && (ioctl_addr[15:0] < TOTAL);
    wr_load = (state_q == StLoad) && ioctl_wr;
    // A new byte may reload the holding register in the same cycle it drains.
    accept  = wr_load && addr_ok && (!pend_q || drain);
    if (ioctl_addr[15:0] < PROG_END) begin
      region_dec = 3'b001;
    end else if (ioctl_addr[15:0] < GFX_END) begin
      region_dec = 3'b010;
    end else begin
      region_dec = 3'b100;
    end
  end

  always_comb begin
    dn_wr      = drain;
    dn_addr    = pend_addr_q;
    dn_data    = pend_data_q;
    region_sel = drain ? pend_region_q : 3'b000;
    core_reset = core_reset_q;
    dl_done    = dl_done_q;
    dl_error   = dl_error_q;
    byte_count = byte_count_q;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StBoot;
      core_reset_q  <= 1'b1;
      dl_done_q     <= 1'b0;
      dl_error_q    <= 1'b0;
      byte_count_q  <= 16'd0;
      settle_cnt_q  <= '0;
      pend_q        <= 1'b0;
      pend_addr_q   <= 16'd0;
      pend_data_q   <= 8'd0;
      pend_region_q <= 3'b000;
    end else begin
      if (accept) begin
        pend_q        <= 1'b1;
        pend_addr_q   <= ioctl_addr[15:0];
        pend_data_q   <= ioctl_dout;
        pend_region_q <= region_dec;
        if (byte_count_q != 16'hFFFF) begin
          byte_count_q <= byte_count_q + 16'd1;
        end
      end else if (drain) begin
        pend_q <= 1'b0;
      end
      // Overrun or out-of-range byte: dropped, uncounted, flagged.
      if (wr_load && !accept) begin
        dl_error_q <= 1'b1;
      end

      unique case (state_q)
        StBoot: begin
          if (ioctl_download) begin
            state_q      <= StLoad;
            byte_count_q <= 16'd0;
            dl_error_q   <= 1'b0;
            pend_q       <= 1'b0;
          end
        end
        StLoad: begin
          if (!ioctl_download) begin
            state_q <= StCheck;
          end
        end
        StCheck: begin
          if (!pend_q) begin
            if ((byte_count_q == TOTAL) && !dl_error_q) begin
              state_q      <= StSettle;
              settle_cnt_q <= '0;
            end else begin
              state_q    <= StBoot;
              dl_error_q <= 1'b1;
            end
          end
        end
        StSettle: begin
          if (user_reset) begin
            settle_cnt_q <= '0;
          end else if (settle_cnt_q == CntLast) begin
            state_q      <= StRun;
            core_reset_q <= 1'b0;
            dl_done_q    <= 1'b1;
          end else begin
            settle_cnt_q <= settle_cnt_q + 1'b1;
          end
        end
        StRun: begin
          if (ioctl_download) begin
            state_q      <= StLoad;
            core_reset_q <= 1'b1;
            dl_done_q    <= 1'b0;
            byte_count_q <= 16'd0;
            dl_error_q   <= 1'b0;
            pend_q       <= 1'b0;
          end else if (user_reset) begin
            state_q      <= StSettle;
            settle_cnt_q <= '0;
            core_reset_q <= 1'b1;
            dl_done_q    <= 1'b0;
          end
        end
        default: begin
          state_q      <= StBoot;
          core_reset_q <= 1'b1;
          dl_done_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cclimb_dl_sequencer.sv
// Directed bench for cclimb_dl_sequencer; region bounds and image size are scaled down so a
// full load is 160 bytes and the settle window is 32 cycles.
module tb_cclimb_dl_sequencer;

  localparam logic [15:0] PE  = 16'h0060;
  localparam logic [15:0] GE  = 16'h0090;
  localparam logic [15:0] TOT = 16'h00A0;
  localparam int unsigned ST  = 32;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        slot_en;
  logic        user_reset = 1'b0;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic [2:0]  region_sel;
  logic        core_reset;
  logic        dl_done;
  logic        dl_error;
  logic [15:0] byte_count;

  int checks = 0;
  int failures = 0;
  int n_push = 0;
  int n_wr = 0;
  bit slot_gate = 1'b1;
  int slot_ph = 0;

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } item_t;
  item_t sb[$];

  cclimb_dl_sequencer #(
    .PROG_END(PE),
    .GFX_END (GE),
    .TOTAL   (TOT),
    .SETTLE  (ST)
  ) dut (
    .clk_sys       (clk_sys),
    .reset_n       (reset_n),
    .ioctl_download(ioctl_download),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .slot_en       (slot_en),
    .user_reset    (user_reset),
    .dn_addr       (dn_addr),
    .dn_data       (dn_data),
    .dn_wr         (dn_wr),
    .region_sel    (region_sel),
    .core_reset    (core_reset),
    .dl_done       (dl_done),
    .dl_error      (dl_error),
    .byte_count    (byte_count)
  );

  always #5 clk_sys = ~clk_sys;

  // Write slot every 4th cycle, maskable to starve the holding register.
  assign slot_en = slot_gate && (slot_ph == 0);
  initial forever begin
    @(posedge clk_sys);
    #1;
    slot_ph = (slot_ph + 1) % 4;
  end

  function automatic logic [2:0] exp_region(logic [15:0] a);
    if (a < PE) return 3'b001;
    if (a < GE) return 3'b010;
    return 3'b100;
  endfunction

  function automatic logic [7:0] pat(logic [24:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic wr_byte(input logic [24:0] a, input bit expect_ok);
    ioctl_addr = a;
    ioctl_dout = pat(a);
    ioctl_wr   = 1'b1;
    if (expect_ok) begin
      sb.push_back({a[15:0], pat(a)});
      n_push++;
    end
    step(1);
    ioctl_wr = 1'b0;
  endtask

  task automatic send(input int n);
    for (int i = 0; i < n; i++) begin
      wr_byte(25'(i), 1'b1);
      step(7);
    end
  endtask

  task automatic begin_dl();
    ioctl_download = 1'b1;
    step(1);
  endtask

  // Download low -> CHECK next edge -> SETTLE -> RUN after ST settle cycles.
  task automatic end_dl_run(input string tag);
    ioctl_download = 1'b0;
    step(ST + 1);
    chk({tag, "_reset_before_settle_end"}, 32'(core_reset), 32'd1);
    step(1);
    chk({tag, "_reset_released"}, 32'(core_reset), 32'd0);
    chk({tag, "_done"}, 32'(dl_done), 32'd1);
    chk({tag, "_error"}, 32'(dl_error), 32'd0);
    chk({tag, "_count"}, 32'(byte_count), 32'(TOT));
    chk({tag, "_pulses"}, 32'(n_wr), 32'(n_push));
  endtask

  // Scoreboard: every dn_wr pops the oldest accepted byte.
  always @(negedge clk_sys) begin
    if (reset_n) begin
      if (dn_wr) begin
        n_wr++;
        chk("dn_wr_in_slot", 32'(slot_en), 32'd1);
        chk("dn_wr_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          item_t it;
          it = sb.pop_front();
          chk("dn_addr", 32'(dn_addr), 32'(it.a));
          chk("dn_data", 32'(dn_data), 32'(it.d));
          chk("region_sel", 32'(region_sel), 32'(exp_region(it.a)));
        end
      end else begin
        chk("region_idle", 32'(region_sel), 32'd0);
      end
    end
  end

  initial begin
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    step(2);
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_dn_wr", 32'(dn_wr), 32'd0);
    reset_n = 1'b1;
    step(50);
    // 1: idle after reset
    chk("idle_core_reset", 32'(core_reset), 32'd1);
    chk("idle_done", 32'(dl_done), 32'd0);
    chk("idle_error", 32'(dl_error), 32'd0);
    chk("idle_count", 32'(byte_count), 32'd0);
    chk("idle_dn_addr", 32'(dn_addr), 32'd0);
    chk("idle_dn_data", 32'(dn_data), 32'd0);
    chk("idle_region", 32'(region_sel), 32'd0);

    // 2: full load
    begin_dl();
    send(int'(TOT));
    end_dl_run("full");

    // 3: overrun with slots starved
    begin_dl();
    chk("ovr_entry_count", 32'(byte_count), 32'd0);
    slot_gate = 1'b0;
    wr_byte(25'h0, 1'b1);
    wr_byte(25'h1, 1'b0);
    step(3);
    chk("ovr_count", 32'(byte_count), 32'd1);
    chk("ovr_error", 32'(dl_error), 32'd1);
    slot_gate = 1'b1;
    step(8);
    ioctl_download = 1'b0;
    step(4);
    chk("ovr_core_reset", 32'(core_reset), 32'd1);
    chk("ovr_done", 32'(dl_done), 32'd0);
    chk("ovr_error_kept", 32'(dl_error), 32'd1);
    chk("ovr_pulses", 32'(n_wr), 32'(n_push));

    // 4: short load, then full reload
    begin_dl();
    chk("short_entry_error", 32'(dl_error), 32'd0);
    send(int'(TOT) - 1);
    ioctl_download = 1'b0;
    step(ST + 4);
    chk("short_error", 32'(dl_error), 32'd1);
    chk("short_core_reset", 32'(core_reset), 32'd1);
    chk("short_done", 32'(dl_done), 32'd0);
    chk("short_count", 32'(byte_count), 32'(TOT - 16'd1));
    begin_dl();
    chk("reload_entry_error", 32'(dl_error), 32'd0);
    chk("reload_entry_count", 32'(byte_count), 32'd0);
    send(int'(TOT));
    end_dl_run("reload");

    // 5: user reset pulse (3 cycles), then download from RUN
    user_reset = 1'b1;
    step(1);
    chk("ur_core_reset_rise", 32'(core_reset), 32'd1);
    chk("ur_done_low", 32'(dl_done), 32'd0);
    step(2);
    user_reset = 1'b0;
    step(ST - 1);
    chk("ur_core_reset_hold", 32'(core_reset), 32'd1);
    step(1);
    chk("ur_core_reset_fall", 32'(core_reset), 32'd0);
    chk("ur_done", 32'(dl_done), 32'd1);
    ioctl_download = 1'b1;
    step(1);
    chk("rdl_core_reset", 32'(core_reset), 32'd1);
    chk("rdl_count", 32'(byte_count), 32'd0);
    chk("rdl_done", 32'(dl_done), 32'd0);
    send(int'(TOT));
    end_dl_run("rdl");

    // 6: out-of-range writes, then async reset mid-load
    begin_dl();
    wr_byte({9'd0, TOT}, 1'b0);
    step(7);
    wr_byte(25'h10000, 1'b0);
    step(7);
    chk("oor_error", 32'(dl_error), 32'd1);
    chk("oor_count", 32'(byte_count), 32'd0);
    chk("oor_pulses", 32'(n_wr), 32'(n_push));
    wr_byte(25'h5, 1'b1);
    step(7);
    chk("mid_count", 32'(byte_count), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("arst_core_reset", 32'(core_reset), 32'd1);
    chk("arst_error", 32'(dl_error), 32'd0);
    chk("arst_count", 32'(byte_count), 32'd0);
    chk("arst_dn_wr", 32'(dn_wr), 32'd0);
    chk("arst_done", 32'(dl_done), 32'd0);
    step(2);
    ioctl_download = 1'b0;
    reset_n = 1'b1;
    step(ST + 10);
    chk("post_core_reset", 32'(core_reset), 32'd1);
    chk("post_done", 32'(dl_done), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
